// File: rtl/bb_stream_tx.sv
// bb_stream_tx: transmitter feeding the baseball-scoring block.
// Buffers per-play records from upstream, streams them as one contiguous
// game with automatic half/inning advance on every third out, then waits
// for the scorer's result and latches it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    pulse: begin a game (honoured only when idle)
//   act_valid/act_ready      upstream play-record handshake
//   act_code, act_outs       play record: action code, outs recorded
//   in_valid, inning, half,  stream to scorer (all zero when in_valid low)
//   action
//   out_valid, score_A,      scorer result
//   score_B, result
//   busy                     a game is in progress
//   done                     pulse: result latched
//   final_A, final_B, winner latched result
//   err                      sticky underrun/timeout flag
module bb_stream_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NUM_INNINGS = 3,
  parameter int unsigned RES_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       act_valid,
  output logic       act_ready,
  input  logic [2:0] act_code,
  input  logic [1:0] act_outs,
  output logic       in_valid,
  output logic [1:0] inning,
  output logic       half,
  output logic [2:0] action,
  input  logic       out_valid,
  input  logic [7:0] score_A,
  input  logic [7:0] score_B,
  input  logic [1:0] result,
  output logic       busy,
  output logic       done,
  output logic [7:0] final_A,
  output logic [7:0] final_B,
  output logic [1:0] winner,
  output logic       err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(RES_TIMEOUT + 1);
  localparam int unsigned REC_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  // Play-record FIFO storage and pointers
  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             act_ready_q;
  logic             push_c, pop_c;
  logic [2:0]       head_code_c;
  logic [1:0]       head_outs_c;

  // Game sequencing state
  logic [1:0]       state_q, state_d;
  logic [1:0]       outs_q, outs_d;
  logic [1:0]       inn_q, inn_d;
  logic             half_q, half_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       sum_c;

  // Registered outputs
  logic             in_valid_q, in_valid_d;
  logic [1:0]       inning_q, inning_d;
  logic             half_o_q, half_o_d;
  logic [2:0]       action_q, action_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic [7:0]       final_a_q, final_a_d;
  logic [7:0]       final_b_q, final_b_d;
  logic [1:0]       winner_q, winner_d;
  logic             err_q, err_d;

  assign push_c      = act_valid && act_ready_q;
  assign head_code_c = mem_q[rd_ptr_q][4:2];
  assign head_outs_c = mem_q[rd_ptr_q][1:0];
  assign sum_c       = {1'b0, outs_q} + {1'b0, head_outs_c};

  // FIFO occupancy; act_ready follows the registered count only
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO data array (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {act_code, act_outs};
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    outs_d     = outs_q;
    inn_d      = inn_q;
    half_d     = half_q;
    timer_d    = timer_q;
    err_d      = err_q;
    done_d     = 1'b0;
    in_valid_d = 1'b0;
    inning_d   = 2'd0;
    half_o_d   = 1'b0;
    action_d   = 3'd0;
    final_a_d  = final_a_q;
    final_b_d  = final_b_q;
    winner_d   = winner_q;
    pop_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRIME;
          err_d   = 1'b0;
          outs_d  = 2'd0;
          inn_d   = 2'd1;
          half_d  = 1'b0;
        end
      end

      ST_PRIME: begin
        if (count_q != CNT_W'(0)) begin
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        if (count_q == CNT_W'(0)) begin
          // Underrun: a play is owed but none is buffered
          err_d   = 1'b1;
          state_d = ST_IDLE;
          outs_d  = 2'd0;
          inn_d   = 2'd1;
          half_d  = 1'b0;
        end else begin
          pop_c      = 1'b1;
          in_valid_d = 1'b1;
          inning_d   = inn_q;
          half_o_d   = half_q;
          action_d   = head_code_c;
          if (sum_c >= 3'd3) begin
            // Third out: the following play belongs to the next half
            outs_d = 2'd0;
            if (half_q) begin
              if (inn_q == 2'(NUM_INNINGS)) begin
                state_d = ST_WAIT;
                timer_d = TMR_W'(0);
                inn_d   = 2'd1;
                half_d  = 1'b0;
              end else begin
                inn_d  = inn_q + 2'd1;
                half_d = 1'b0;
              end
            end else begin
              half_d = 1'b1;
            end
          end else begin
            outs_d = sum_c[1:0];
          end
        end
      end

      ST_WAIT: begin
        if (out_valid) begin
          final_a_d = score_A;
          final_b_d = score_B;
          winner_d  = result;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else if (timer_q == TMR_W'(RES_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      act_ready_q <= 1'b1;
      outs_q      <= 2'd0;
      inn_q       <= 2'd1;
      half_q      <= 1'b0;
      timer_q     <= '0;
      in_valid_q  <= 1'b0;
      inning_q    <= 2'd0;
      half_o_q    <= 1'b0;
      action_q    <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      final_a_q   <= 8'd0;
      final_b_q   <= 8'd0;
      winner_q    <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q     <= count_d;
      act_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      outs_q      <= outs_d;
      inn_q       <= inn_d;
      half_q      <= half_d;
      timer_q     <= timer_d;
      in_valid_q  <= in_valid_d;
      inning_q    <= inning_d;
      half_o_q    <= half_o_d;
      action_q    <= action_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
      final_a_q   <= final_a_d;
      final_b_q   <= final_b_d;
      winner_q    <= winner_d;
      err_q       <= err_d;
    end
  end

  assign act_ready = act_ready_q;
  assign in_valid  = in_valid_q;
  assign inning    = inning_q;
  assign half      = half_o_q;
  assign action    = action_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign final_A   = final_a_q;
  assign final_B   = final_b_q;
  assign winner    = winner_q;
  assign err       = err_q;

endmodule

// File: doc/bb_stream_tx.md
Name: bb_stream_tx

Overview:
- Transmitter side of the baseball-scoring stream: feeds the scoring block's input port, consumes its result.
- Upstream pushes per-play records (action code + outs recorded) through a valid/ready port into an internal FIFO.
- Block sequences them onto in_valid/inning/half/action as one contiguous game, auto-advances half/inning on every third out, then waits for and latches the scorer's result.

Parameters:
FIFO_DEPTH, 4, play-record FIFO entries (power of 2, >=2)
NUM_INNINGS, 3, innings per game; inning field counts 1..NUM_INNINGS
RES_TIMEOUT, 1023, max cycles waited for out_valid after the last play

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin a game; ignored unless state IDLE
act_valid  in  1  upstream play record valid
act_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
act_code  in  3  action code forwarded verbatim to action
act_outs  in  2  outs recorded by this play (0..3)
in_valid  out  1  stream valid to scorer
inning  out  2  current inning, 1..NUM_INNINGS; 0 when in_valid low
half  out  1  0 top (team A bats), 1 bottom; 0 when in_valid low
action  out  3  play code; 0 when in_valid low
out_valid  in  1  scorer result valid
score_A  in  8  scorer final score A
score_B  in  8  scorer final score B
result  in  2  scorer winner code
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: result latched
final_A  out  8  latched score_A
final_B  out  8  latched score_B
winner  out  2  latched result
err  out  1  sticky: underrun or timeout; cleared by next accepted start

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0 except act_ready=1; outs counter 0, inning reg 1, half reg 0.
- FIFO: push on act_valid&&act_ready, pop on each emitted play. act_ready from registered count; when full, no push even if a pop occurs that cycle. Push+pop when not full: count unchanged. Pushes are accepted in any state (preload).
- IDLE: start -> PRIME; clear err, outs=0, inning=1, half=0.
- PRIME: wait for FIFO non-empty, then SEND next cycle (registered outputs).
- SEND: every cycle pop head and drive in_valid=1, inning, half, action=act_code (registered; 1-cycle latency from pop to pins).
  - sum = outs + act_outs (3-bit); sum >= 3 -> outs=0 and the next play uses the next half: half 0->1 same inning; half 1 -> inning+1, half 0.
  - Third out with half=1 and inning=NUM_INNINGS: that play is the last; in_valid drops the following cycle -> WAIT_RES. Remaining FIFO entries stay for the next game.
  - FIFO empty while in SEND (play needed, none available): underrun -> err=1, in_valid=0, state IDLE, counters reset; no done.
- WAIT_RES: timer counts cycles; out_valid=1 -> latch score_A, score_B, result into final_A/final_B/winner, done=1 for one cycle, -> IDLE. Timer reaches RES_TIMEOUT -> err=1, IDLE, finals unchanged.
- out_valid in any other state ignored. start outside IDLE ignored.
- Async rst mid-game: immediate return to reset values, FIFO flushed.
- in_valid is high on exactly the game's play count of consecutive cycles, never with a gap.

Test Plan:
- Preload 9 records {code 7, outs 1}, start -> 9 consecutive in_valid cycles: inning/half = (1,0)x3, (1,1)x3, (2,0)x3; then underrun err=1, busy=0.
- Full game: 18 records {code 6, outs 1} plus one {code 4, outs 0} first -> 19 contiguous cycles ending (3,1); scorer returns out_valid with A=1, B=0, result=1 -> final_A=1, final_B=0, winner=1, done pulse.
- Double-play carry: outs=1, push {6, 2} -> half flips after that play, outs restart at 0; {5, 3} from outs=0 ends half.
- FIFO full: push 4 while idle -> act_ready=0; fifth act_valid not accepted; single pop restores act_ready next cycle.
- Timeout: complete game, hold out_valid=0 for RES_TIMEOUT cycles -> err=1, no done, finals keep previous values; next start clears err.
- Reset asserted during SEND at play 5 -> outputs 0 same cycle, FIFO empty, act_ready=1 after release.
